// File: rtl/linear_proj_out_writer_if.sv
// Result-beat stream into the output writer plus the output BRAM write port it drives.
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready; in_data must be stable while in_valid is high, and in_ready never depends combinationally on in_valid.
interface linear_proj_out_writer_if #(
    parameter int IN_W    = 1024,
    parameter int SLICE_W = 128,
    parameter int ADDR_W  = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic               bram_we;
    logic [ADDR_W-1:0]  bram_addr;
    logic [SLICE_W-1:0] bram_din;

    modport master (output in_valid, output in_data, input in_ready,
                    input bram_we, input bram_addr, input bram_din);
    modport slave  (input in_valid, input in_data, output in_ready,
                    output bram_we, output bram_addr, output bram_din);
endinterface

// File: rtl/linear_proj_out_writer.sv
// Captures one result beat per output tile of C and writes its slices, one per cycle,
// to the output BRAM at row-major addresses; pulses done after the last tile.
module linear_proj_out_writer #(
    parameter int WIDTH_OUT      = 16,
    parameter int CHUNK_SIZE     = 4,
    parameter int NUM_CORES_A    = 2,
    parameter int NUM_CORES_B    = 1,
    parameter int TOTAL_INPUT_W  = 2,
    parameter int TOTAL_MODULES  = 4,
    parameter int ROW_SIZE_MAT_C = 1,
    parameter int COL_SIZE_MAT_C = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state,
    linear_proj_out_writer_if.slave bus
);
    localparam int SLICE_W  = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B;
    localparam int N_SLICE  = TOTAL_INPUT_W * TOTAL_MODULES;
    localparam int MAX_FLAG = ROW_SIZE_MAT_C * COL_SIZE_MAT_C;
    localparam int ADDR_W   = ($clog2(MAX_FLAG * N_SLICE) > 1) ? $clog2(MAX_FLAG * N_SLICE) : 1;
    localparam int IN_W     = N_SLICE * SLICE_W;
    localparam int RW = (ROW_SIZE_MAT_C > 1) ? $clog2(ROW_SIZE_MAT_C) : 1;
    localparam int CW = (COL_SIZE_MAT_C > 1) ? $clog2(COL_SIZE_MAT_C) : 1;
    localparam int WW = (TOTAL_INPUT_W > 1) ? $clog2(TOTAL_INPUT_W) : 1;
    localparam int MW = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1;

    localparam logic [RW-1:0] R_LAST = RW'(ROW_SIZE_MAT_C - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COL_SIZE_MAT_C - 1);
    localparam logic [WW-1:0] W_LAST = WW'(TOTAL_INPUT_W - 1);
    localparam logic [MW-1:0] M_LAST = MW'(TOTAL_MODULES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

    state_t              state, state_n;
    logic [RW-1:0]       row, row_n;
    logic [CW-1:0]       col, col_n;
    logic [WW-1:0]       w, w_n;
    logic [MW-1:0]       m, m_n;
    logic [IN_W-1:0]     cap, cap_n;
    logic                rdy_q, rdy_n, we_q, we_n, busy_q, busy_n, done_q, done_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [SLICE_W-1:0]  din_q, din_n;
    int                  sel;

    function automatic logic [ADDR_W-1:0] calc_addr(input int r, input int c,
                                                    input int ww, input int mm);
        int a;
        a = (r * TOTAL_INPUT_W + ww) * (COL_SIZE_MAT_C * TOTAL_MODULES) + c * TOTAL_MODULES + mm;
        return ADDR_W'(a);
    endfunction

    // Outputs are registered, so each cycle computes the write that appears next cycle.
    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        w_n     = w;
        m_n     = m;
        cap_n   = cap;
        rdy_n   = rdy_q;
        we_n    = 1'b0;
        busy_n  = busy_q;
        done_n  = 1'b0;
        addr_n  = addr_q;
        din_n   = din_q;
        sel     = 0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = WAIT;
                    row_n   = '0;
                    col_n   = '0;
                    rdy_n   = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            WAIT: begin
                if (bus.in_valid && rdy_q) begin
                    cap_n   = bus.in_data;
                    state_n = WRITE;
                    w_n     = '0;
                    m_n     = '0;
                    rdy_n   = 1'b0;
                    we_n    = 1'b1;
                    addr_n  = calc_addr(int'(row), int'(col), 0, 0);
                    din_n   = bus.in_data[SLICE_W-1:0];
                end
            end
            WRITE: begin
                if (w == W_LAST && m == M_LAST) begin
                    if (row == R_LAST && col == C_LAST) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        row_n   = '0;
                        col_n   = '0;
                    end else begin
                        state_n = WAIT;
                        rdy_n   = 1'b1;
                        if (col == C_LAST) begin
                            col_n = '0;
                            row_n = row + RW'(1);
                        end else begin
                            col_n = col + CW'(1);
                        end
                    end
                end else begin
                    if (m == M_LAST) begin
                        m_n = '0;
                        w_n = w + WW'(1);
                    end else begin
                        m_n = m + MW'(1);
                    end
                    sel    = int'(w_n) * TOTAL_MODULES + int'(m_n);
                    we_n   = 1'b1;
                    addr_n = calc_addr(int'(row), int'(col), int'(w_n), int'(m_n));
                    din_n  = cap[sel*SLICE_W +: SLICE_W];
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            row    <= '0;
            col    <= '0;
            w      <= '0;
            m      <= '0;
            cap    <= '0;
            rdy_q  <= 1'b0;
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            state  <= state_n;
            row    <= row_n;
            col    <= col_n;
            w      <= w_n;
            m      <= m_n;
            cap    <= cap_n;
            rdy_q  <= rdy_n;
            we_q   <= we_n;
            busy_q <= busy_n;
            done_q <= done_n;
            addr_q <= addr_n;
            din_q  <= din_n;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.bram_we   = we_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_din  = din_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign dbg_state     = state;
endmodule

// File: doc/linear_proj_out_writer.md
# linear_proj_out_writer

Output-side stage of the linear projection. Consumes the result beats from the multi-matmul wrapper, one beat per output tile of matrix C. Each beat is serialized into per-module slices and written, one per cycle, to the output BRAM at row-major addresses. A done pulse is raised after the last of ROW_SIZE_MAT_C × COL_SIZE_MAT_C tiles has been written, and the downstream stage starts on that pulse.

## Interface
- WIDTH_OUT, 16: output element width
- CHUNK_SIZE, 4: elements per core chunk
- NUM_CORES_A, 2: A-side cores per module
- NUM_CORES_B, 1: B-side cores per module
- TOTAL_INPUT_W, 2: input ports per beat
- TOTAL_MODULES, 4: matmul modules per beat
- ROW_SIZE_MAT_C, 1: tile rows of C (package formula)
- COL_SIZE_MAT_C, 1: tile columns of C (package formula)
- Derived:
  - SLICE_W = WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B
  - N_SLICE = TOTAL_INPUT_W*TOTAL_MODULES
  - MAX_FLAG = ROW_SIZE_MAT_C*COL_SIZE_MAT_C
  - ADDR_W = max(1, $clog2(MAX_FLAG*N_SLICE))
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a projection pass; sampled only in IDLE
- in_valid  in  1  result beat available
- in_ready  out  1  writer can accept a beat
- in_data  in  N_SLICE*SLICE_W  slice s=w*TOTAL_MODULES+m at [s*SLICE_W +: SLICE_W]
- bram_we  out  1  output BRAM write enable
- bram_addr  out  ADDR_W  output BRAM address
- bram_din  out  SLICE_W  output BRAM write data
- busy  out  1  high from the start acceptance until done
- done  out  1  one-cycle pulse after the final write

## Operation
- States:
  - IDLE: waits for start; on start goes to WAIT with tile counters row=0, col=0.
  - WAIT: in_ready=1; on in_valid registers in_data into a capture register and goes to WRITE with w=0, m=0.
  - WRITE: in_ready=0, bram_we=1. Drives the slice selected by (w, m), with m incrementing fastest. After slice (TOTAL_INPUT_W-1, TOTAL_MODULES-1), the tile counter advances: col increments first and wraps to 0 with row+1. If the tile just written was the last one (row=ROW_SIZE_MAT_C-1, col=COL_SIZE_MAT_C-1), next state is DONE; otherwise WAIT.
  - DONE: done=1 for one cycle, then IDLE.
- Address: bram_addr = (row*TOTAL_INPUT_W + w)*(COL_SIZE_MAT_C*TOTAL_MODULES) + col*TOTAL_MODULES + m. Arithmetic is unsigned and truncated to ADDR_W, with no overflow for legal parameters.
- Data is passed through bit-exact; the block does no arithmetic on it.
- start outside IDLE is ignored. in_valid outside WAIT is ignored, and the data is not consumed because in_ready=0.
- Reset, asserted at any time, forces IDLE, clears counters, and drops all outputs to 0; any partial tile is discarded.

## Timing
- Reset values: in_ready=0, bram_we=0, bram_addr=0, bram_din=0, busy=0, done=0.
- All outputs are registered.
- start is sampled in cycle T; in_ready=1 from T+1.
- A beat is accepted in cycle T, when in_valid & in_ready are both high. bram_we is high in cycles T+1 through T+N_SLICE, and in_ready is low during the same cycles.
- Next in_ready=1 at T+N_SLICE+1, so the maximum throughput is one beat per N_SLICE+1 cycles.
- After the final tile's last write in cycle L, done=1 in L+1 and busy=0 from L+2. A new start is accepted from L+2.
- MAX_FLAG=1 is legal: a single beat is accepted, then done follows.

## Test plan
- Defaults (N_SLICE=8, MAX_FLAG=1), start, then one beat with slice s = 0x1000+s in every element → 8 writes at addr 0..7, din in order s=0..7, done at the cycle after addr 7, busy then low.
- Override ROW=2, COL=2, TOTAL_MODULES=2, TOTAL_INPUT_W=2; 4 beats → write addresses are tile(0,0): 0,1,4,5; tile(0,1): 2,3,6,7; tile(1,0): 8,9,12,13; tile(1,1): 10,11,14,15; one done pulse.
- in_valid held high continuously → in_ready pulses every 9 cycles; each beat is written exactly once; beats are never dropped or duplicated.
- in_valid asserted during WRITE and in IDLE → no capture and no write; a start pulse during WRITE has no effect.
- rst_n asserted in the middle of the 3rd slice → all outputs 0 immediately. After release with a new start, writes restart from addr 0 with the first beat.
- in_valid delayed by 20 random cycles between beats → addresses and data are unchanged versus back-to-back; done still follows the last write by exactly 1 cycle.
